// File: rtl/qft_sub_sched.sv
// Pair-walking sequencer for one QFT emulator pass: reads amplitude pairs that differ in the
// target qubit's bit, runs them through an external alu_sub, and writes the result to the upper address.
module qft_sub_sched #(
  parameter int sample_size    = 4,
  parameter int complexnum_bit = 24,
  parameter int fp_bit         = 22,
  localparam int QW = ($clog2(sample_size + 1) > 1) ? $clog2(sample_size + 1) : 1,
  localparam int KW = (sample_size > 1) ? sample_size - 1 : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [QW-1:0]             qubit,
  input  logic [complexnum_bit:0]   phase,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_rd_en,
  output logic [sample_size-1:0]    mem_rd_addr,
  input  logic [complexnum_bit-1:0] mem_rd_data,
  output logic                      mem_wr_en,
  output logic [sample_size-1:0]    mem_wr_addr,
  output logic [complexnum_bit-1:0] mem_wr_data,
  output logic [complexnum_bit-1:0] alu_in1,
  output logic [complexnum_bit-1:0] alu_in2,
  output logic [complexnum_bit:0]   alu_in3,
  input  logic [complexnum_bit-1:0] alu_out,
  output logic [2:0]                dbg_state
);

  // The result slice taken by alu_sub only makes sense with fewer fractional than total bits.
  if (fp_bit >= complexnum_bit) begin : g_bad_fp
    $error("qft_sub_sched: fp_bit must be smaller than complexnum_bit");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_CAP_B = 3'd3,
    S_EXEC  = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [QW:0] SS_W = (QW + 1)'(sample_size);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [QW-1:0]             r_q;
  logic [complexnum_bit:0]   r_phase;
  logic [KW-1:0]             r_k;
  logic [complexnum_bit-1:0] r_a;
  logic [complexnum_bit-1:0] r_b;
  logic [complexnum_bit-1:0] r_res;
  logic                      r_err;

  logic                      w_q_ok;
  logic                      w_last_pair;
  logic [sample_size-1:0]    w_k_ext;
  logic [sample_size-1:0]    w_low_mask;
  logic [sample_size-1:0]    w_i;
  logic [sample_size-1:0]    w_j;

  assign w_q_ok      = ({1'b0, qubit} < SS_W);
  assign w_last_pair = (r_k == '1);

  // i is k with a zero spliced in at bit q; j is the same address with that bit set.
  assign w_k_ext    = sample_size'(r_k);
  assign w_low_mask = (sample_size'(1) << r_q) - sample_size'(1);
  assign w_i        = ((w_k_ext >> r_q) << (r_q + QW'(1))) | (w_k_ext & w_low_mask);
  assign w_j        = w_i | (sample_size'(1) << r_q);

  assign alu_in1   = r_a;
  assign alu_in2   = r_b;
  assign alu_in3   = r_phase;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_phase <= '0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_q_ok) begin
              r_q     <= qubit;
              r_phase <= phase;
              r_k     <= '0;
              r_err   <= 1'b0;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        // Read data lags the strobe by one cycle, so A lands during the read of j.
        S_RD_B:  r_a   <= mem_rd_data;
        S_CAP_B: r_b   <= mem_rd_data;
        S_EXEC:  r_res <= alu_out;
        S_WR: begin
          if (!w_last_pair) begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_q_ok ? S_RD_A : S_DONE;
        end
      end
      S_RD_A: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_i;
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_j;
        w_state_nxt = S_CAP_B;
      end
      S_CAP_B: begin
        busy        = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy        = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = w_j;
        mem_wr_data = r_res;
        w_state_nxt = w_last_pair ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_qft_sub_sched.sv
// Bench for qft_sub_sched: behavioural RAM and alu_sub stand-in, table of full passes,
// plus hand sequences for arithmetic corners, reset mid-pass and ignored restart.
module tb_qft_sub_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  qubit;
  logic [24:0] phase;
  logic        busy, done, err;
  logic        mem_rd_en, mem_wr_en;
  logic [3:0]  mem_rd_addr, mem_wr_addr;
  logic [23:0] mem_rd_data, mem_wr_data;
  logic [23:0] alu_in1, alu_in2, alu_out;
  logic [24:0] alu_in3;
  logic [2:0]  dbg_state;

  qft_sub_sched dut (
    .clk(clk), .rst(rst), .start(start), .qubit(qubit), .phase(phase),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3), .alu_out(alu_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1);
  end

  logic [23:0] mem [16];
  logic [23:0] load_img [16];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 16; n++) mem[n] <= load_img[n];
    end else begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end
  end

  function automatic logic [23:0] alu_fn(input logic [23:0] a, input logic [23:0] b,
                                         input logic [24:0] p);
    logic signed [24:0] d;
    logic signed [49:0] prod;
    d    = $signed({a[23], a}) - $signed({b[23], b});
    prod = d * $signed(p);
    return prod[45:22];
  endfunction

  assign alu_out = alu_fn(alu_in1, alu_in2, alu_in3);

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [27:0] exp_q[$];
  logic [3:0]  wr_addr_q[$];
  logic [23:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int done_cyc, n_rd, n_busy, n_overlap;
  logic err_seen, post_busy, post_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic load_ramp();
    for (int n = 0; n < 16; n++) load_img[n] = 24'(n * 24'h010000);
    do_load();
  endtask

  // ---------------- driver ----------------
  // Starts a pass and records every strobe until done (bounded); glitch > 0 pulses start in that cycle.
  task automatic run_pass(input logic [2:0] q, input logic [24:0] ph, input int glitch);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc = -1; n_rd = 0; n_busy = 0; n_overlap = 0; err_seen = 1'b0;
    qubit = q; phase = ph; start = 1'b1;
    step();
    start = 1'b0;
    qubit = q ^ 3'b001;
    phase = ~ph;
    for (int c = 1; c <= 60; c++) begin
      start = (c == glitch);
      if (mem_rd_en && mem_wr_en) n_overlap++;
      if (mem_rd_en) n_rd++;
      if (busy) n_busy++;
      if (mem_wr_en) begin
        wr_addr_q.push_back(mem_wr_addr);
        wr_data_q.push_back(mem_wr_data);
        wr_cyc_q.push_back(c);
      end
      if (done) begin
        done_cyc = c;
        err_seen = err;
        break;
      end
      step();
    end
    start = 1'b0;
    step();
    post_busy = busy;
    post_done = done;
  endtask

  typedef struct {
    logic [2:0]  q;
    logic [24:0] ph;
    logic        exp_err;
    int          exp_done;
    int          exp_nwr;
    logic [31:0] addrs;   // expected write addresses, first write in the top nibble
    logic [23:0] data;
    int          glitch;
  } vec_t;

  task automatic apply_vec(input vec_t v, input string tag);
    logic [23:0] exp_img [16];
    load_ramp();
    for (int n = 0; n < 16; n++) exp_img[n] = 24'(n * 24'h010000);
    exp_q.delete();
    for (int n = 0; n < v.exp_nwr; n++) begin
      logic [3:0] a;
      a = v.addrs[31 - 4 * n -: 4];
      exp_q.push_back({a, v.data});
      exp_img[a] = v.data;
    end
    run_pass(v.q, v.ph, v.glitch);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    chk({tag, "_err"}, 64'(err_seen), 64'(v.exp_err));
    chk({tag, "_busy_cycles"}, 64'(n_busy), 64'(v.exp_done));
    chk({tag, "_read_count"}, 64'(n_rd), 64'(2 * v.exp_nwr));
    chk({tag, "_rd_wr_overlap"}, 64'(n_overlap), 64'd0);
    chk({tag, "_post_done_busy_done"}, {62'd0, post_busy, post_done}, 64'd0);
    chk({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(v.exp_nwr));
    for (int n = 0; n < wr_addr_q.size(); n++) begin
      if (exp_q.size() > 0) begin
        logic [27:0] e;
        e = exp_q.pop_front();
        chk({tag, "_write_addr_data"}, {36'd0, wr_addr_q[n], wr_data_q[n]}, {36'd0, e});
        chk({tag, "_write_cycle"}, 64'(wr_cyc_q[n]), 64'(5 * (n + 1)));
      end
    end
    for (int a = 0; a < 16; a++) chk({tag, "_mem_image"}, 64'(mem[a]), 64'(exp_img[a]));
  endtask

  vec_t vecs [5];
  vec_t v_q1;

  initial begin
    vecs[0] = '{q: 3'd0, ph: 25'h0400000, exp_err: 1'b0, exp_done: 41, exp_nwr: 8,
                addrs: 32'h13579BDF, data: 24'hFF0000, glitch: 0};
    vecs[1] = '{q: 3'd3, ph: 25'h0400000, exp_err: 1'b0, exp_done: 41, exp_nwr: 8,
                addrs: 32'h89ABCDEF, data: 24'hF80000, glitch: 0};
    vecs[2] = '{q: 3'd2, ph: 25'h0400000, exp_err: 1'b0, exp_done: 41, exp_nwr: 8,
                addrs: 32'h4567CDEF, data: 24'hFC0000, glitch: 0};
    vecs[3] = '{q: 3'd4, ph: 25'h0400000, exp_err: 1'b1, exp_done: 1, exp_nwr: 0,
                addrs: 32'h0, data: 24'h0, glitch: 0};
    vecs[4] = '{q: 3'd7, ph: 25'h1E00000, exp_err: 1'b1, exp_done: 1, exp_nwr: 0,
                addrs: 32'h0, data: 24'h0, glitch: 0};
    v_q1    = '{q: 3'd1, ph: 25'h0400000, exp_err: 1'b0, exp_done: 41, exp_nwr: 8,
                addrs: 32'h2367ABEF, data: 24'hFE0000, glitch: 20};

    // Reset held three cycles with start asserted.
    rst = 1'b1; start = 1'b1; qubit = 3'd0; phase = 25'h0400000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_ctrl", {59'd0, busy, done, err, mem_rd_en, mem_wr_en}, 64'd0);
      chk("reset_addr_data", {28'd0, mem_rd_addr, mem_wr_addr, mem_wr_data}, 64'd0);
      chk("reset_alu_in", {9'd0, alu_in3, alu_in1 | alu_in2}, 64'd0);
      chk("reset_state", 64'(dbg_state), 64'd0);
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_after_release", {60'd0, dbg_state, busy}, 64'd0);
    end

    for (int n = 0; n < 5; n++) apply_vec(vecs[n], $sformatf("vec%0d", n));

    // Phase -0.5, plus a pair with a full-scale difference.
    for (int n = 0; n < 16; n++) load_img[n] = 24'h0;
    load_img[0] = 24'h100000; load_img[1] = 24'hF00000;
    load_img[2] = 24'h7FFFFF; load_img[3] = 24'h800000;
    do_load();
    run_pass(3'd0, 25'h1E00000, 0);
    chk("neg_half_done_cycle", 64'(done_cyc), 64'd41);
    chk("neg_half_mem1", 64'(mem[1]), 64'hF00000);
    chk("neg_half_mem3", 64'(mem[3]), 64'h800000);
    chk("neg_half_mem0_kept", 64'(mem[0]), 64'h100000);
    chk("neg_half_mem2_kept", 64'(mem[2]), 64'h7FFFFF);
    chk("neg_half_mem5", 64'(mem[5]), 64'h0);

    // Near-4.0 phase: products exceed the word and wrap.
    for (int n = 0; n < 16; n++) load_img[n] = 24'h0;
    load_img[0] = 24'h400000; load_img[1] = 24'h000000;
    load_img[2] = 24'h000001; load_img[3] = 24'h7FFFFF;
    do_load();
    run_pass(3'd0, 25'h0FFFFFF, 0);
    chk("ovf_done_cycle", 64'(done_cyc), 64'd41);
    chk("ovf_mem1", 64'(mem[1]), 64'hFFFFFF);
    chk("ovf_mem3", 64'(mem[3]), 64'h000009);

    // Reset asserted in cycle 12 of a q=0 pass.
    load_ramp();
    begin
      int n_wr, n_late, n_done;
      n_wr = 0; n_late = 0; n_done = 0;
      qubit = 3'd0; phase = 25'h0400000; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 50; c++) begin
        if (c == 12) rst = 1'b1;
        if (c == 14) rst = 1'b0;
        if (mem_wr_en) n_wr++;
        if (done) n_done++;
        if (c >= 13 && (mem_rd_en || mem_wr_en || busy)) n_late++;
        step();
      end
      chk("midreset_writes", 64'(n_wr), 64'd2);
      chk("midreset_done", 64'(n_done), 64'd0);
      chk("midreset_activity_after", 64'(n_late), 64'd0);
      chk("midreset_state", 64'(dbg_state), 64'd0);
      chk("midreset_mem1", 64'(mem[1]), 64'hFF0000);
      chk("midreset_mem5_untouched", 64'(mem[5]), 64'h050000);
    end

    // Restart with q=1; a stray start in cycle 20 is ignored.
    apply_vec(v_q1, "restart_q1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
